// File: rtl/ransac_residual_sequencer.sv
// Computes r = a*x + b*y + c as two chained FMA ops on a shared FMA unit and flags |r| <= threshold.
// Latency: 1 accept cycle + two FMA round trips + 1 result cycle; min one idle cycle between samples.
// Backpressure: in_ready low from accept until the result transfers; operands/result held until ready.
package ransac_fixed;
    localparam int fixed_width   = 32;
    localparam int fraction_bits = 16;

    typedef logic signed [fixed_width-1:0] fixed_t;

    localparam fixed_t fixed_max = {1'b0, {(fixed_width-1){1'b1}}};
    localparam fixed_t fixed_min = {1'b1, {(fixed_width-1){1'b0}}};

    typedef enum logic [1:0] {
        FMA_OPCODE_POS_A_POS_C = 2'd0,
        FMA_OPCODE_NEG_A_POS_C = 2'd1,
        FMA_OPCODE_POS_A_NEG_C = 2'd2,
        FMA_OPCODE_NEG_A_NEG_C = 2'd3
    } fma_opcode_t;
endpackage

module ransac_residual_sequencer
    import ransac_fixed::*;
#(
    parameter int unsigned timeout_cycles = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  fixed_t      line_a,
    input  fixed_t      line_b,
    input  fixed_t      line_c,
    input  fixed_t      point_x,
    input  fixed_t      point_y,
    input  fixed_t      threshold,
    output logic        fma_input_valid,
    input  logic        fma_input_ready,
    output fixed_t      fma_a,
    output fixed_t      fma_b,
    output fixed_t      fma_c,
    output fma_opcode_t fma_opcode,
    input  logic        fma_output_valid,
    input  fixed_t      fma_r,
    output logic        out_valid,
    input  logic        out_ready,
    output fixed_t      residual,
    output logic        is_inlier,
    output logic        fma_timeout
);

    localparam int unsigned CNT_W = $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

    typedef struct packed {
        fixed_t a;
        fixed_t b;
        fixed_t c;
        fixed_t x;
        fixed_t y;
        fixed_t thr;
    } sample_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_WAIT1  = 3'd2,
        ST_ISSUE2 = 3'd3,
        ST_WAIT2  = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_low_q, seen_low_d;
    sample_t          sample_q, sample_d;
    fixed_t           t_q, t_d;
    fixed_t           residual_q, residual_d;
    logic             is_inlier_q, is_inlier_d;
    logic             fma_timeout_q, fma_timeout_d;

    logic   cnt_expired;
    logic   result_hit;
    logic   timeout_hit;
    logic   in_fma_step;
    fixed_t r_abs;
    logic   r_inlier;

    assign cnt_expired = (cnt_q == CNT_LAST);
    // A result only counts once the FMA has dropped the level left over from its previous op.
    assign result_hit  = seen_low_q && fma_output_valid;
    assign in_fma_step = (state_q == ST_ISSUE1) || (state_q == ST_WAIT1) ||
                         (state_q == ST_ISSUE2) || (state_q == ST_WAIT2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_ISSUE1;
            end
            ST_ISSUE1: begin
                if (fma_input_ready) begin
                    state_d = ST_WAIT1;
                end else if (cnt_expired) begin
                    state_d     = ST_RESULT;
                    timeout_hit = 1'b1;
                end
            end
            ST_WAIT1: begin
                if (result_hit) begin
                    state_d = ST_ISSUE2;
                end else if (cnt_expired) begin
                    state_d     = ST_RESULT;
                    timeout_hit = 1'b1;
                end
            end
            ST_ISSUE2: begin
                if (fma_input_ready) begin
                    state_d = ST_WAIT2;
                end else if (cnt_expired) begin
                    state_d     = ST_RESULT;
                    timeout_hit = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (result_hit) begin
                    state_d = ST_RESULT;
                end else if (cnt_expired) begin
                    state_d     = ST_RESULT;
                    timeout_hit = 1'b1;
                end
            end
            ST_RESULT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready        = (state_q == ST_IDLE);
        fma_input_valid = (state_q == ST_ISSUE1) || (state_q == ST_ISSUE2);
        out_valid       = (state_q == ST_RESULT);
        fma_a           = sample_q.b;
        fma_b           = sample_q.y;
        fma_c           = sample_q.c;
        if (state_q == ST_ISSUE2) begin
            fma_a = sample_q.a;
            fma_b = sample_q.x;
            fma_c = t_q;
        end
    end

    assign fma_opcode  = FMA_OPCODE_POS_A_POS_C;
    assign residual    = residual_q;
    assign is_inlier   = is_inlier_q;
    assign fma_timeout = fma_timeout_q;

    // Negating the most-negative value would wrap, so it saturates to the largest positive.
    always_comb begin
        r_abs = fma_r;
        if (fma_r == fixed_min) begin
            r_abs = fixed_max;
        end else if (fma_r < 0) begin
            r_abs = -fma_r;
        end
        r_inlier = (r_abs <= $signed(sample_q.thr));
    end

    always_comb begin
        sample_d      = sample_q;
        t_d           = t_q;
        residual_d    = residual_q;
        is_inlier_d   = is_inlier_q;
        fma_timeout_d = fma_timeout_q | timeout_hit;
        seen_low_d    = seen_low_q;
        cnt_d         = cnt_q;

        if (state_q == ST_IDLE && in_valid) begin
            sample_d = '{a: line_a, b: line_b, c: line_c,
                         x: point_x, y: point_y, thr: threshold};
        end
        if (state_q == ST_WAIT1 && result_hit) begin
            t_d = fma_r;
        end
        if (state_q == ST_WAIT2 && result_hit) begin
            residual_d  = fma_r;
            is_inlier_d = r_inlier;
        end
        if (timeout_hit) begin
            residual_d  = '0;
            is_inlier_d = 1'b0;
        end

        if (state_d != state_q) begin
            seen_low_d = 1'b0;
            cnt_d      = '0;
        end else begin
            if ((state_q == ST_WAIT1 || state_q == ST_WAIT2) && !fma_output_valid) begin
                seen_low_d = 1'b1;
            end
            cnt_d = in_fma_step ? cnt_q + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            seen_low_q    <= 1'b0;
            sample_q      <= '0;
            t_q           <= '0;
            residual_q    <= '0;
            is_inlier_q   <= 1'b0;
            fma_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            seen_low_q    <= seen_low_d;
            sample_q      <= sample_d;
            t_q           <= t_d;
            residual_q    <= residual_d;
            is_inlier_q   <= is_inlier_d;
            fma_timeout_q <= fma_timeout_d;
        end
    end

endmodule
